// File: rtl/if_stage_pkg.sv
// Shared types and constants for the sMIPS instruction-fetch stage.
package if_stage_pkg;

  typedef enum logic [1:0] {
    IF_S_REQ  = 2'd0,
    IF_S_WAIT = 2'd1,
    IF_S_FULL = 2'd2,
    IF_S_DROP = 2'd3
  } if_state_t;

  localparam int          INST_ADDR_BUS = 32;
  localparam int          INST_BUS      = 32;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
  localparam logic        RST_ENABLE    = 1'b1;

  typedef struct packed {
    logic [INST_ADDR_BUS-1:0] pc;
    logic [INST_BUS-1:0]      inst;
  } fetch_word_t;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID boundary register with a one-entry skid; a word loads one edge after it arrives.
// Stall holds the output and diverts a late arrival into the skid; flush clears both.
module if_id_reg
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        load,
  input  fetch_word_t load_word,
  output logic        slot_free,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        inst_valid
);

  fetch_word_t skid_word;
  logic        skid_valid;

  assign slot_free = !inst_valid || !stall;

  // pc is left alone on flush/consume so decode still sees the last address.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      pc         <= ZERO_WORD;
      inst       <= ZERO_WORD;
      inst_valid <= 1'b0;
      skid_valid <= 1'b0;
      skid_word  <= '0;
    end else if (flush) begin
      inst       <= ZERO_WORD;
      inst_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (load && slot_free) begin
      pc         <= load_word.pc;
      inst       <= load_word.inst;
      inst_valid <= 1'b1;
    end else if (load) begin
      skid_word  <= load_word;
      skid_valid <= 1'b1;
    end else if (skid_valid && !stall) begin
      pc         <= skid_word.pc;
      inst       <= skid_word.inst;
      inst_valid <= 1'b1;
      skid_valid <= 1'b0;
    end else if (inst_valid && !stall) begin
      inst       <= ZERO_WORD;
      inst_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, one outstanding imem read; rvalid reaches inst_o next edge.
// Decode stall parks a late response in the skid; redirect flushes and drops any in-flight read.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  if_state_t   state, state_nxt;
  logic [31:0] fetch_pc;
  logic [31:0] req_pc;
  logic        handshake;
  logic        load;
  logic        slot_free;
  fetch_word_t load_word;

  assign handshake = (state == IF_S_REQ) && imem_ack_i;
  assign load      = (state == IF_S_WAIT) && imem_rvalid_i;
  assign load_word = '{pc: req_pc, inst: imem_rdata_i};

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) state <= IF_S_REQ;
    else                   state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (redirect_i) begin
      // Any response still owed by memory must be swallowed before refetching.
      case (state)
        IF_S_REQ:  state_nxt = imem_ack_i    ? IF_S_DROP : IF_S_REQ;
        IF_S_WAIT: state_nxt = imem_rvalid_i ? IF_S_REQ  : IF_S_DROP;
        IF_S_DROP: state_nxt = imem_rvalid_i ? IF_S_REQ  : IF_S_DROP;
        default:   state_nxt = IF_S_REQ;
      endcase
    end else begin
      case (state)
        IF_S_REQ:  if (imem_ack_i)    state_nxt = IF_S_WAIT;
        IF_S_WAIT: if (imem_rvalid_i) state_nxt = slot_free ? IF_S_REQ : IF_S_FULL;
        IF_S_FULL: if (!stall_i)      state_nxt = IF_S_REQ;
        IF_S_DROP: if (imem_rvalid_i) state_nxt = IF_S_REQ;
        default:                      state_nxt = IF_S_REQ;
      endcase
    end
  end

  always_comb begin
    imem_req_o  = (state == IF_S_REQ);
    imem_addr_o = fetch_pc;
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      fetch_pc <= RESET_PC;
      req_pc   <= ZERO_WORD;
    end else if (redirect_i) begin
      fetch_pc <= align_pc(redirect_pc_i);
    end else if (handshake) begin
      req_pc   <= fetch_pc;
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall_i),
    .flush      (redirect_i),
    .load       (load),
    .load_word  (load_word),
    .slot_free  (slot_free),
    .pc         (pc_o),
    .inst       (inst_o),
    .inst_valid (inst_valid_o)
  );

endmodule
